// File: rtl/fp_exp_align_4_if.sv
// Valid/ready bundle for the 4-lane exponent-alignment stage.
// The slave side is the alignment stage itself.
interface fp_exp_align_4_if #(
  parameter int unsigned EXP_W = 6,
  parameter int unsigned MAN_W = 8,
  parameter int unsigned GRD_W = 3
);
  localparam int unsigned AW = MAN_W + GRD_W;

  logic                 i_valid;
  logic                 o_ready;
  logic [4*EXP_W-1:0]   i_exp_array;
  logic [4*MAN_W-1:0]   i_man_array;
  logic                 o_valid;
  logic                 i_ready;
  logic [EXP_W-1:0]     o_max_exp;
  logic [4*AW-1:0]      o_man_array;

  modport slave (
    input  i_valid, i_exp_array, i_man_array, i_ready,
    output o_ready, o_valid, o_max_exp, o_man_array
  );

  modport master (
    output i_valid, i_exp_array, i_man_array, i_ready,
    input  o_ready, o_valid, o_max_exp, o_man_array
  );
endinterface

// File: rtl/fp_exp_align_4.sv
// Two-stage exponent alignment: S1 finds the max exponent and per-lane shift distances,
// S2 arithmetic-shifts each mantissa (with guard bits) and folds shifted-out bits into a sticky LSB.
module fp_exp_align_4 #(
  parameter int unsigned EXP_W = 6,
  parameter int unsigned MAN_W = 8,
  parameter int unsigned GRD_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  fp_exp_align_4_if.slave    bus
);
  localparam int unsigned AW = MAN_W + GRD_W;
  // Shift distances at or beyond the lane width saturate to sign fill.
  localparam logic [EXP_W-1:0] AwSat = EXP_W'(AW);

  logic               s1_valid_q, s1_valid_d;
  logic               s2_valid_q, s2_valid_d;
  logic               s1_adv, s2_adv, in_fire, s1_fire;
  logic [EXP_W-1:0]   s1_max_q, s1_max_d;
  logic [EXP_W-1:0]   s2_max_q, s2_max_d;
  logic [4*EXP_W-1:0] s1_diff_q, s1_diff_d;
  logic [4*MAN_W-1:0] s1_man_q, s1_man_d;
  logic [4*AW-1:0]    s2_man_q, s2_man_d;
  logic [EXP_W-1:0]   max_exp;
  logic [4*AW-1:0]    aligned;
  logic [MAN_W-1:0]   lane_man;
  logic [EXP_W-1:0]   lane_diff;
  logic [AW-1:0]      lane_ext, lane_sh;
  logic               lane_sticky;

  assign s2_adv  = ~s2_valid_q | bus.i_ready;
  assign s1_adv  = ~s1_valid_q | s2_adv;
  assign in_fire = bus.i_valid & s1_adv;
  assign s1_fire = s1_valid_q & s2_adv;

  always_comb begin
    max_exp = bus.i_exp_array[0 +: EXP_W];
    for (int k = 1; k < 4; k++) begin
      if (bus.i_exp_array[k*EXP_W +: EXP_W] > max_exp) begin
        max_exp = bus.i_exp_array[k*EXP_W +: EXP_W];
      end
    end
  end

  always_comb begin
    aligned     = '0;
    lane_man    = '0;
    lane_diff   = '0;
    lane_ext    = '0;
    lane_sh     = '0;
    lane_sticky = 1'b0;
    for (int k = 0; k < 4; k++) begin
      lane_man  = s1_man_q[k*MAN_W +: MAN_W];
      lane_diff = s1_diff_q[k*EXP_W +: EXP_W];
      lane_ext  = {lane_man, {GRD_W{1'b0}}};
      if (lane_diff >= AwSat) begin
        lane_sh     = {AW{lane_man[MAN_W-1]}};
        lane_sticky = |lane_man;
      end else begin
        lane_sh     = $signed(lane_ext) >>> lane_diff;
        lane_sticky = |(lane_ext & ~({AW{1'b1}} << lane_diff));
      end
      aligned[k*AW +: AW] = {lane_sh[AW-1:1], lane_sh[0] | lane_sticky};
    end
  end

  always_comb begin
    s1_valid_d = s1_adv ? bus.i_valid : s1_valid_q;
    s1_max_d   = s1_max_q;
    s1_diff_d  = s1_diff_q;
    s1_man_d   = s1_man_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_max_d   = s2_max_q;
    s2_man_d   = s2_man_q;
    if (in_fire) begin
      s1_max_d = max_exp;
      s1_man_d = bus.i_man_array;
      for (int k = 0; k < 4; k++) begin
        s1_diff_d[k*EXP_W +: EXP_W] = max_exp - bus.i_exp_array[k*EXP_W +: EXP_W];
      end
    end
    if (s1_fire) begin
      s2_max_d = s1_max_q;
      s2_man_d = aligned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_max_q   <= '0;
      s1_diff_q  <= '0;
      s1_man_q   <= '0;
      s2_max_q   <= '0;
      s2_man_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_max_q   <= s1_max_d;
      s1_diff_q  <= s1_diff_d;
      s1_man_q   <= s1_man_d;
      s2_max_q   <= s2_max_d;
      s2_man_q   <= s2_man_d;
    end
  end

  assign bus.o_ready     = s1_adv;
  assign bus.o_valid     = s2_valid_q;
  assign bus.o_max_exp   = s2_max_q;
  assign bus.o_man_array = s2_man_q;
endmodule

// File: tb/tb_fp_exp_align_4.sv
// Scoreboard bench for fp_exp_align_4: directed vectors, backpressure, reset mid-flight, random.
module tb_fp_exp_align_4;
  typedef struct packed {
    logic [5:0]  mx;
    logic [43:0] man;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  res_t sb[$];

  fp_exp_align_4_if #(.EXP_W(6), .MAN_W(8), .GRD_W(3)) bus ();

  fp_exp_align_4 #(.EXP_W(6), .MAN_W(8), .GRD_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: scale by 8, floor-divide by 2^d, sticky if the division was inexact.
  function automatic res_t model(input logic [23:0] e, input logic [31:0] m);
    res_t        r;
    int          mx;
    int          d;
    int          v;
    int          sh;
    bit          st;
    logic [31:0] shv;
    mx = 0;
    for (int k = 0; k < 4; k++) if (int'(e[k*6 +: 6]) > mx) mx = int'(e[k*6 +: 6]);
    r.mx  = 6'(mx);
    r.man = '0;
    for (int k = 0; k < 4; k++) begin
      d = mx - int'(e[k*6 +: 6]);
      v = 8 * int'($signed(m[k*8 +: 8]));
      if (d > 30) begin
        sh = (v < 0) ? -1 : 0;
        st = (v != 0);
      end else begin
        sh = v >>> d;
        st = ((sh <<< d) != v);
      end
      shv = sh;
      r.man[k*11 +: 11] = {shv[10:1], shv[0] | st};
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic [23:0] e, input logic [31:0] m,
                       input logic rdy);
    bus.i_valid     = v;
    bus.i_exp_array = e;
    bus.i_man_array = m;
    bus.i_ready     = rdy;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    #1;
    vectors++;
    if (bus.o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_o_valid: got %b want 0", bus.o_valid);
    end
    vectors++;
    if (bus.o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_o_ready: got %b want 1", bus.o_ready);
    end
    vectors++;
    if (bus.o_max_exp !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_o_max_exp: got %h want 0", bus.o_max_exp);
    end
    vectors++;
    if (bus.o_man_array !== 44'd0) begin
      miscompares++;
      $display("FAIL reset_o_man_array: got %h want 0", bus.o_man_array);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [23:0] ev[3];
    logic [31:0] mv[3];
    res_t        xv[3];
    ev[0] = {6'd7, 6'd12, 6'd12, 6'd10};
    mv[0] = {8'h41, 8'hC0, 8'h40, 8'h40};
    xv[0] = {6'd12, 11'h011, 11'h600, 11'h200, 11'h080};
    ev[1] = {6'd0, 6'd0, 6'd0, 6'd40};
    mv[1] = {8'h00, 8'h80, 8'h7F, 8'h01};
    xv[1] = {6'd40, 11'h000, 11'h7FF, 11'h001, 11'h008};
    ev[2] = {6'd5, 6'd5, 6'd5, 6'd5};
    mv[2] = {8'h80, 8'hFF, 8'h02, 8'h01};
    xv[2] = {6'd5, 11'h400, 11'h7F8, 11'h010, 11'h008};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 3) drive(1'b1, ev[c], mv[c], 1'b1);
      else drive(1'b0, '0, '0, 1'b1);
      #1;
      vectors++;
      if (bus.o_valid !== (c >= 2 && c <= 4)) begin
        miscompares++;
        $display("FAIL basic_latency c=%0d: o_valid %b want %b", c, bus.o_valid,
                 (c >= 2 && c <= 4));
      end
      if (c >= 2 && c <= 4) begin
        vectors++;
        if ({bus.o_max_exp, bus.o_man_array} !== xv[c-2]) begin
          miscompares++;
          $display("FAIL basic_data set%0d: got %h/%h want %h/%h", c - 2, bus.o_max_exp,
                   bus.o_man_array, xv[c-2].mx, xv[c-2].man);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    res_t  x;
    logic  exp_rdy;
    logic  held = 1'b0;
    res_t  held_val = '0;
    int    sent = 0;
    for (int c = 0; c < 40 && (sent < 6 || sb.size() != 0); c++) begin
      @(negedge clk);
      drive(sent < 6, {6'(c), 6'(c + 3), 6'(2 * c), 6'(c + 9)}, 32'($urandom),
            (c % 4 == 0) || (c % 4 == 3));
      #1;
      if (held) begin
        vectors++;
        if (bus.o_valid !== 1'b1 || {bus.o_max_exp, bus.o_man_array} !== held_val) begin
          miscompares++;
          $display("FAIL bp_stall_stable: got %b %h/%h want 1 %h/%h", bus.o_valid,
                   bus.o_max_exp, bus.o_man_array, held_val.mx, held_val.man);
        end
      end
      exp_rdy = !(sb.size() == 2 && !bus.i_ready);
      vectors++;
      if (bus.o_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL bp_o_ready: got %b want %b", bus.o_ready, exp_rdy);
      end
      held     = bus.o_valid && !bus.i_ready;
      held_val = {bus.o_max_exp, bus.o_man_array};
      if (bus.o_valid && bus.i_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL bp_spurious: got %h/%h want no output", bus.o_max_exp, bus.o_man_array);
        end else begin
          x = sb.pop_front();
          if ({bus.o_max_exp, bus.o_man_array} !== x) begin
            miscompares++;
            $display("FAIL bp_data: got %h/%h want %h/%h", bus.o_max_exp, bus.o_man_array,
                     x.mx, x.man);
          end
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        sb.push_back(model(bus.i_exp_array, bus.i_man_array));
        sent++;
      end
    end
    vectors++;
    if (sent != 6 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL bp_drain: sent %0d pending %0d want 6 sent 0 pending", sent, sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic [23:0] e;
    logic [31:0] m;
    res_t        x;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(c < 2, {6'd1, 6'd2, 6'd3, 6'(c + 4)}, 32'($urandom), 1'b0);
      #1;
    end
    vectors++;
    if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_full_pipe: o_ready %b o_valid %b want 0 1", bus.o_ready, bus.o_valid);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_async_drop: o_valid %b o_ready %b want 0 1", bus.o_valid, bus.o_ready);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    e = {6'd20, 6'd3, 6'd17, 6'd9};
    m = {8'h9C, 8'h33, 8'hF1, 8'h7E};
    x = model(e, m);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) drive(1'b1, e, m, 1'b1);
      else drive(1'b0, '0, '0, 1'b1);
      #1;
      vectors++;
      if (bus.o_valid !== (c == 2)) begin
        miscompares++;
        $display("FAIL rst_latency c=%0d: o_valid %b want %b", c, bus.o_valid, (c == 2));
      end
      if (c == 2) begin
        vectors++;
        if ({bus.o_max_exp, bus.o_man_array} !== x) begin
          miscompares++;
          $display("FAIL rst_after_data: got %h/%h want %h/%h", bus.o_max_exp,
                   bus.o_man_array, x.mx, x.man);
        end
      end
    end
  endtask

  task automatic test_random();
    res_t        x;
    logic        exp_rdy;
    logic [23:0] e;
    int          sent = 0;
    int          c = 0;
    while ((sent < 10000 || sb.size() != 0) && c < 60000) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 0) e = 24'($urandom);
      else e = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
                6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
      drive((sent < 10000) && ($urandom_range(0, 3) != 0), e, 32'($urandom),
            (sent >= 10000) || ($urandom_range(0, 3) != 0));
      #1;
      exp_rdy = !(sb.size() == 2 && !bus.i_ready);
      vectors++;
      if (bus.o_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL rnd_o_ready: got %b want %b", bus.o_ready, exp_rdy);
      end
      if (bus.o_valid && bus.i_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_spurious: got %h/%h want no output", bus.o_max_exp,
                   bus.o_man_array);
        end else begin
          x = sb.pop_front();
          if ({bus.o_max_exp, bus.o_man_array} !== x) begin
            miscompares++;
            $display("FAIL rnd_data: got %h/%h want %h/%h", bus.o_max_exp, bus.o_man_array,
                     x.mx, x.man);
          end
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        sb.push_back(model(bus.i_exp_array, bus.i_man_array));
        sent++;
      end
      c++;
    end
    vectors++;
    if (sent != 10000 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_complete: sent %0d pending %0d want 10000 sent 0 pending", sent,
               sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
